uart_rx_block: RTL and testbench
================================

// Module: uart_rx_block
// PURPOSE
//  8N1 UART receiver; receive-side counterpart of the tx_block/uart_clk_gen path.
//  Oversamples the async serial line at 16x baud and recovers each frame.
//  Presents each byte with a one-cycle valid strobe; flags bad stop bits.
//  Self-contained divider: does not use uart_clk_gen's clk_en.
// PARAMETERS
//  CLK_FREQ    44_000_000  system clock frequency, Hz
//  BAUD        115_200     line rate, bit/s
//  OVERSAMPLE  16          samples per bit (fixed 16; any other value is unsupported)
//  DIV         CLK_FREQ/(BAUD*OVERSAMPLE), rounded to nearest (localparam); min 2
// PORTS
//  clk         in   1  system clock, all logic on rising edge
//  rst         in   1  synchronous, active-high reset
//  rx_in       in   1  asynchronous serial line, idle high
//  data_out    out  8  last received byte, LSB = first data bit on line
//  data_valid  out  1  one-cycle pulse: data_out holds a new good byte
//  frame_err   out  1  one-cycle pulse: stop bit sampled low
//  busy        out  1  high while a frame is being received (state != IDLE)
// BEHAVIOUR
//  Reset: data_out=0, data_valid=0, frame_err=0, busy=0, state=IDLE,
//   both synchroniser flops=1, all counters=0. Reset mid-frame aborts the frame, no pulse.
//  Input: 2-flop synchroniser -> rx_s; plus rx_d (rx_s delayed 1 cycle) for edge detect.
//  Tick: divider counts 0..DIV-1, tick=1 when count==DIV-1; cleared to 0 on start edge.
//  Sample counter s: 0..15 per bit, advances on tick; wraps 15->0 with bit index++.
//  Bit decision: majority of rx_s taken at ticks s=7,8,9; decided on tick s=9.
//  FSM:
//   IDLE : on rx_d=1 & rx_s=0 (falling edge) -> START; divider, s, bit index cleared.
//          Level low without an edge (break / post-error) never starts a frame.
//   START: at s=9 vote=1 -> IDLE (glitch rejected, no pulse); vote=0 -> continue;
//          at s=15 tick -> DATA, bit index=0.
//   DATA : at s=9 shift vote into shift reg, LSB first; after 8th bit's s=15 tick -> STOP.
//   STOP : at s=9: vote=1 -> data_out<=shift reg, data_valid=1 next cycle;
//          vote=0 -> frame_err=1 next cycle, data_out unchanged. Then -> IDLE
//          immediately (mid-stop) so a back-to-back start edge is caught.
//  data_valid and frame_err never high together; each high exactly 1 cycle.
//  Latency: pulse ~9.5 bit periods (+2 sync +1 out cycles) after line falling edge.
//  Tolerance: correct reception with combined baud error up to +/-3%.
//  busy=1 from cycle after edge detect until the cycle the FSM returns to IDLE.
//  data_out holds its value until the next good frame.
// TESTING  (bench overrides CLK_FREQ=1_600_000, BAUD=10_000 -> DIV=10, 160 clk/bit)
//  1 Frame 0xA5, stop=1 -> data_out=0xA5, data_valid high 1 cycle, frame_err stays 0.
//  2 Low glitch 40 clk then high -> no data_valid/frame_err; busy falls within 1 bit.
//  3 Frame 0x3C with stop bit low -> frame_err 1 cycle, data_valid 0, data_out unchanged.
//  4 0x00 then 0xFF back-to-back (no idle gap) -> two data_valid pulses, bytes in order.
//  5 rst at data bit 4 of a frame, line high 2 bits, send 0x81 -> outputs 0 during rst,
//     then 0x81 received once; no spurious pulse from the aborted frame.
//  6 Frames 0x55 sent at BAUD*1.03 and BAUD*0.97 -> both received, no frame_err.

Source files
------------

// File: rtl/uart_rx_block.sv
// uart_rx_block: 8N1 UART receiver with 16x oversampling and majority voting.
// Each recovered byte is presented with a one-cycle data_valid strobe; a low
// stop bit produces a one-cycle frame_err strobe instead.

module uart_rx_block #(
  parameter int CLK_FREQ   = 44_000_000,
  parameter int BAUD       = 115_200,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int DIV_RAW = (CLK_FREQ + (BAUD * OVERSAMPLE) / 2) / (BAUD * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 2) ? 2 : DIV_RAW;
  localparam int DW      = $clog2(DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state;
  state_t          state_next;
  logic            sync1;
  logic            rx_s;
  logic            rx_d;
  logic [DW-1:0]   div_cnt;
  logic [3:0]      s_cnt;
  logic [2:0]      bit_idx;
  logic            samp7;
  logic            samp8;
  logic [7:0]      shift_reg;

  logic            start_edge;
  logic            tick;
  logic            vote;
  logic            mid_tick;
  logic            end_tick;
  logic            stop_good;
  logic            stop_bad;

  assign start_edge = rx_d & ~rx_s;
  assign tick       = (div_cnt == DIV_LAST);
  assign mid_tick   = tick && (s_cnt == 4'd9);
  assign end_tick   = tick && (s_cnt == 4'd15);
  assign vote       = (samp7 & samp8) | (samp7 & rx_s) | (samp8 & rx_s);

  // Bring the asynchronous line into the clock domain and keep a delayed copy for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      sync1 <= rx_in;
      rx_s  <= sync1;
      rx_d  <= rx_s;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic: a frame only starts on a genuine falling edge, and STOP exits mid-bit
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:  if (start_edge) state_next = START;
      START: begin
        if (mid_tick && vote)  state_next = IDLE;
        else if (end_tick)     state_next = DATA;
      end
      DATA:  if (end_tick && (bit_idx == 3'd7)) state_next = STOP;
      STOP:  if (mid_tick) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode: busy level and the stop-bit verdicts that launch the result strobes
  always_comb begin
    busy      = (state != IDLE);
    stop_good = (state == STOP) && mid_tick && vote;
    stop_bad  = (state == STOP) && mid_tick && !vote;
  end

  // Datapath: baud divider, sample/bit counters, vote samples, shift register and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt    <= '0;
      s_cnt      <= '0;
      bit_idx    <= '0;
      samp7      <= 1'b0;
      samp8      <= 1'b0;
      shift_reg  <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      data_valid <= stop_good;
      frame_err  <= stop_bad;
      if (stop_good) data_out <= shift_reg;

      if ((state == IDLE) && start_edge) begin
        div_cnt <= '0;
        s_cnt   <= '0;
        bit_idx <= '0;
      end else begin
        div_cnt <= tick ? '0 : div_cnt + 1'b1;
        if (tick && (state != IDLE)) begin
          s_cnt <= s_cnt + 4'd1;
          if (s_cnt == 4'd7) samp7 <= rx_s;
          if (s_cnt == 4'd8) samp8 <= rx_s;
          if ((s_cnt == 4'd9) && (state == DATA)) shift_reg <= {vote, shift_reg[7:1]};
          if (s_cnt == 4'd15) begin
            if (state == START)     bit_idx <= '0;
            else if (state == DATA) bit_idx <= bit_idx + 3'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_block.sv
// tb_uart_rx_block: drives serial frames at nominal and skewed baud rates,
// records every result strobe, and compares against an event list built
// from the frames that were sent.

module tb_uart_rx_block;

  localparam real BIT_T = 1600.0;

  logic       clk;
  logic       rst;
  logic       rx_in;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       busy;

  int check_cnt = 0;
  int fail_cnt  = 0;

  logic [8:0] exp_q[$];
  logic [8:0] obs_q[$];
  logic [7:0] last_good;

  int   overlap_cnt = 0;
  int   wide_cnt    = 0;
  logic prev_valid  = 1'b0;
  logic prev_err    = 1'b0;

  uart_rx_block #(
    .CLK_FREQ(1_600_000),
    .BAUD(10_000),
    .OVERSAMPLE(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx_in(rx_in),
    .data_out(data_out),
    .data_valid(data_valid),
    .frame_err(frame_err),
    .busy(busy)
  );

  // Free-running clock, 10 time units per cycle
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Record every result strobe and watch for overlapping or stretched pulses
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
      prev_err   = 1'b0;
    end else begin
      if (data_valid) obs_q.push_back({1'b0, data_out});
      if (frame_err)  obs_q.push_back({1'b1, data_out});
      if (data_valid && frame_err) overlap_cnt++;
      if ((data_valid && prev_valid) || (frame_err && prev_err)) wide_cnt++;
      prev_valid = data_valid;
      prev_err   = frame_err;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_cnt++;
    if (observed !== expected) begin
      fail_cnt++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Reference model: a good frame yields its byte, a bad stop yields an error carrying the last good byte
  task automatic expectFrame(input logic [7:0] b, input logic stop_bit);
    if (stop_bit) begin
      exp_q.push_back({1'b0, b});
      last_good = b;
    end else begin
      exp_q.push_back({1'b1, last_good});
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b, input logic stop_bit, input real bt);
    rx_in = 1'b0;
    #(bt);
    for (int i = 0; i < 8; i++) begin
      rx_in = b[i];
      #(bt);
    end
    rx_in = stop_bit;
    #(bt);
    rx_in = 1'b1;
  endtask

  task automatic compareEvents(input string tag);
    checkOutput({tag, "_count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checkOutput({tag, "_kind"}, {31'd0, obs_q[i][8]}, {31'd0, exp_q[i][8]});
      checkOutput({tag, "_data"}, {24'd0, obs_q[i][7:0]}, {24'd0, exp_q[i][7:0]});
    end
    checkOutput({tag, "_hold"}, {24'd0, data_out}, {24'd0, last_good});
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [7:0] rb;
    logic       rstop;
    real        rbt;

    rst       = 1'b1;
    rx_in     = 1'b1;
    last_good = 8'h00;
    repeat (5) @(negedge clk);
    checkOutput("rst_data", {24'd0, data_out}, 32'd0);
    checkOutput("rst_valid", {31'd0, data_valid}, 32'd0);
    checkOutput("rst_err", {31'd0, frame_err}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    #(2 * BIT_T);

    // Single good frame
    expectFrame(8'hA5, 1'b1);
    applyStimulus(8'hA5, 1'b1, BIT_T);
    #(2 * BIT_T);
    compareEvents("frame_a5");

    // Short low glitch must be rejected before the end of the start bit
    @(negedge clk);
    rx_in = 1'b0;
    repeat (40) @(negedge clk);
    rx_in = 1'b1;
    checkOutput("glitch_busy_hi", {31'd0, busy}, 32'd1);
    repeat (160) @(negedge clk);
    checkOutput("glitch_busy_lo", {31'd0, busy}, 32'd0);
    #(BIT_T);
    compareEvents("glitch");

    // Stop bit low
    expectFrame(8'h3C, 1'b0);
    applyStimulus(8'h3C, 1'b0, BIT_T);
    #(2 * BIT_T);
    compareEvents("bad_stop");

    // Back-to-back frames with no idle gap
    expectFrame(8'h00, 1'b1);
    expectFrame(8'hFF, 1'b1);
    applyStimulus(8'h00, 1'b1, BIT_T);
    applyStimulus(8'hFF, 1'b1, BIT_T);
    #(2 * BIT_T);
    compareEvents("b2b");

    // Reset in the middle of data bit 4 aborts the frame
    rb = 8'h6B;
    rx_in = 1'b0;
    #(BIT_T);
    for (int i = 0; i < 4; i++) begin
      rx_in = rb[i];
      #(BIT_T);
    end
    rx_in = rb[4];
    #(BIT_T / 2);
    @(negedge clk);
    rst   = 1'b1;
    rx_in = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("midrst_data", {24'd0, data_out}, 32'd0);
    checkOutput("midrst_valid", {31'd0, data_valid}, 32'd0);
    checkOutput("midrst_err", {31'd0, frame_err}, 32'd0);
    checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
    rst       = 1'b0;
    last_good = 8'h00;
    obs_q.delete();
    #(2 * BIT_T);
    expectFrame(8'h81, 1'b1);
    applyStimulus(8'h81, 1'b1, BIT_T);
    #(2 * BIT_T);
    compareEvents("after_rst");

    // Baud rate skew at +3% and -3%
    expectFrame(8'h55, 1'b1);
    applyStimulus(8'h55, 1'b1, BIT_T / 1.03);
    #(2 * BIT_T);
    expectFrame(8'h55, 1'b1);
    applyStimulus(8'h55, 1'b1, BIT_T / 0.97);
    #(2 * BIT_T);
    compareEvents("skew");

    // Random bytes, stop bits, gaps and small baud errors
    for (int n = 0; n < 12; n++) begin
      rb    = 8'($urandom_range(0, 255));
      rstop = ($urandom_range(0, 3) != 0);
      rbt   = BIT_T * (1.0 + (real'($urandom_range(0, 40)) - 20.0) / 1000.0);
      expectFrame(rb, rstop);
      applyStimulus(rb, rstop, rbt);
      #(rbt * real'($urandom_range(0, 3)));
    end
    #(2 * BIT_T);
    compareEvents("random");

    checkOutput("pulse_overlap", overlap_cnt, 32'd0);
    checkOutput("pulse_width", wide_cnt, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", check_cnt, fail_cnt);
    $finish;
  end

endmodule
